core_id: RTL
============

// Module: core_id
// PURPOSE
// - IF->ID stage: registers fetch output (fd_*) into a 2-entry skid buffer and decodes RV32I fields.
// - Presents a fully registered decoded instruction to execute (de_*) under valid/ready handshake.
// - Sits directly downstream of core_if; drives core_if's fd_ready, honours pipeline flush and ctr_stop.
// PARAMETERS
// - XLEN   32   datapath / pc width
// PORTS
// clk           in   1     clock
// rest          in   1     synchronous active-high reset
// fd_istr       in   32    instruction from fetch; [1:0]!=2'b11 means 16-bit compressed in [15:0]
// fd_pc         in   32    pc of fd_istr
// fd_valid      in   1     fetch output valid
// fd_jump       in   1     fetch/bp predicted this instruction taken
// fd_ready      out  1     ID can accept fd_* this cycle
// flush_en      in   1     discard all buffered instructions
// ctr_stop      in   1     freeze stage (no accept, no issue)
// de_valid      out  1     decoded instruction valid
// de_ready      in   1     execute accepts de_* this cycle
// de_pc         out  32    pc
// de_pc_next    out  32    de_pc+4 (de_pc+2 when compressed)
// de_istr       out  32    raw instruction
// de_opclass    out  4     0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OPIMM,8 OP,9 MISCMEM,10 SYSTEM,15 illegal
// de_funct3     out  3     istr[14:12]
// de_funct7     out  7     istr[31:25]
// de_rs1/rs2/rd out  5    register indices istr[19:15]/[24:20]/[11:7]
// de_rs1_en     out  1     rs1 read needed
// de_rs2_en     out  1     rs2 read needed (BRANCH, STORE, OP)
// de_rd_en      out  1     rd write needed and rd!=0
// de_imm        out  32    sign-extended immediate per format (I/S/B/U/J), 0 for OP
// de_jump       out  1     registered fd_jump
// de_illegal    out  1     unknown opcode or compressed instruction
// BEHAVIOUR
// - Reset: all entries invalid; de_valid=0, fd_ready=1; all de_* data outputs 0.
// - Accept when fd_valid&&fd_ready; issue when de_valid&&de_ready. Latency 1 cycle, throughput 1/cycle.
// - State = occupancy {EMPTY, ONE (out reg), TWO (out reg + skid)}; fd_ready = (state!=TWO)&&!ctr_stop, from registers only.
//   EMPTY: accept -> ONE (decode written to out reg).
//   ONE:   accept&&issue -> ONE (new into out); accept&&!issue -> TWO (new into skid); issue only -> EMPTY.
//   TWO:   issue -> ONE (skid moves to out reg); no accept possible.
// - Decode performed on input before registering; skid stores decoded fields, not raw, so skid->out is a copy.
// - Order preserved: skid is always younger than out reg.
// - flush_en: next cycle state=EMPTY, de_valid=0; fd_* presented in flush cycle dropped; issue in flush cycle
//   still counts for execute (execute sees flush too). flush_en has priority over accept/issue.
// - ctr_stop: de_valid forced 0 and fd_ready 0 while high; buffer contents and state retained; resumes unchanged.
// - rest mid-operation: same as reset, overrides flush and stop.
// - Immediates: I={20{i[31]},i[31:20]}; S={20{i[31]},i[31:25],i[11:7]}; B={19{i[31]},i[31],i[7],i[30:25],i[11:8],0};
//   U={i[31:12],12'b0}; J={11{i[31]},i[31],i[19:12],i[20],i[30:21],0}.
// - Compressed input: de_opclass=15, de_illegal=1, all *_en=0, de_pc_next=pc+2; pc arithmetic wraps mod 2^32.
// - Illegal: all *_en=0, de_imm=0.
// TESTING
// 1. Reset then fd 0x00510093 pc=0x100 -> next cycle de_valid=1, opclass 7, rs1=2, rd=1, imm=5, rd_en=1, pc_next=0x104.
// 2. fd 0xFE208EE3 (beq x1,x2,-4) -> opclass 4, rs1=1, rs2=2, rs2_en=1, rd_en=0, imm=0xFFFFFFFC.
// 3. de_ready=0, stream 3 instrs -> fd_ready drops after 2 accepted; raise de_ready -> issued in order, none lost.
// 4. State TWO + flush_en 1 cycle with fd_valid=1 -> next cycle de_valid=0, fd_ready=1; dropped instr never issues.
// 5. fd 0x00004505 (c.li) pc=0xFFFFFFFE -> de_illegal=1, opclass 15, de_pc_next=0x00000000.
// 6. ctr_stop held 5 cycles in state ONE -> de_valid=0, fd_ready=0; release -> same instr issued; rest mid-stream empties.

Source files
------------

// File: rtl/core_id.sv
// IF->ID stage: two-entry skid buffer holding pre-decoded RV32I instructions,
// presented to execute through a registered valid/ready interface.
module core_id #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rest,
  input  logic [31:0]     fd_istr,
  input  logic [XLEN-1:0] fd_pc,
  input  logic            fd_valid,
  input  logic            fd_jump,
  output logic            fd_ready,
  input  logic            flush_en,
  input  logic            ctr_stop,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_next,
  output logic [31:0]     de_istr,
  output logic [3:0]      de_opclass,
  output logic [2:0]      de_funct3,
  output logic [6:0]      de_funct7,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic [4:0]      de_rd,
  output logic            de_rs1_en,
  output logic            de_rs2_en,
  output logic            de_rd_en,
  output logic [31:0]     de_imm,
  output logic            de_jump,
  output logic            de_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     istr;
    logic [3:0]      opclass;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_en;
    logic [31:0]     imm;
    logic            jump;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  dec_t   out_q, out_d, skid_q, skid_d, dec;
  logic   accept, issue;

  // Decode the incoming instruction so both buffer entries hold finished fields.
  always_comb begin
    logic        compressed;
    logic        rs1_w, rs2_w, rd_w;
    logic [31:0] i;
    i           = fd_istr;
    compressed  = (i[1:0] != 2'b11);
    rs1_w       = 1'b0;
    rs2_w       = 1'b0;
    rd_w        = 1'b0;
    dec         = '0;
    dec.pc      = fd_pc;
    dec.pc_next = fd_pc + (compressed ? XLEN'(2) : XLEN'(4));
    dec.istr    = i;
    dec.funct3  = i[14:12];
    dec.funct7  = i[31:25];
    dec.rs1     = i[19:15];
    dec.rs2     = i[24:20];
    dec.rd      = i[11:7];
    dec.jump    = fd_jump;
    dec.opclass = 4'd15;
    dec.illegal = 1'b1;
    if (!compressed) begin
      dec.illegal = 1'b0;
      case (i[6:0])
        7'b0110111: begin dec.opclass = 4'd0;  rd_w = 1'b1; dec.imm = {i[31:12], 12'b0}; end
        7'b0010111: begin dec.opclass = 4'd1;  rd_w = 1'b1; dec.imm = {i[31:12], 12'b0}; end
        7'b1101111: begin
          dec.opclass = 4'd2;
          rd_w        = 1'b1;
          dec.imm     = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        end
        7'b1100111: begin
          dec.opclass = 4'd3;
          rs1_w       = 1'b1;
          rd_w        = 1'b1;
          dec.imm     = {{20{i[31]}}, i[31:20]};
        end
        7'b1100011: begin
          dec.opclass = 4'd4;
          rs1_w       = 1'b1;
          rs2_w       = 1'b1;
          dec.imm     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        end
        7'b0000011: begin
          dec.opclass = 4'd5;
          rs1_w       = 1'b1;
          rd_w        = 1'b1;
          dec.imm     = {{20{i[31]}}, i[31:20]};
        end
        7'b0100011: begin
          dec.opclass = 4'd6;
          rs1_w       = 1'b1;
          rs2_w       = 1'b1;
          dec.imm     = {{20{i[31]}}, i[31:25], i[11:7]};
        end
        7'b0010011: begin
          dec.opclass = 4'd7;
          rs1_w       = 1'b1;
          rd_w        = 1'b1;
          dec.imm     = {{20{i[31]}}, i[31:20]};
        end
        7'b0110011: begin dec.opclass = 4'd8; rs1_w = 1'b1; rs2_w = 1'b1; rd_w = 1'b1; end
        7'b0001111: begin dec.opclass = 4'd9;  dec.imm = {{20{i[31]}}, i[31:20]}; end
        7'b1110011: begin dec.opclass = 4'd10; dec.imm = {{20{i[31]}}, i[31:20]}; end
        default:    dec.illegal = 1'b1;
      endcase
    end
    dec.rs1_en = rs1_w;
    dec.rs2_en = rs2_w;
    dec.rd_en  = rd_w && (i[11:7] != 5'd0);
  end

  assign fd_ready = (state_q != StTwo) && !ctr_stop;
  assign de_valid = (state_q != StEmpty) && !ctr_stop;
  assign accept   = fd_valid && fd_ready;
  assign issue    = de_valid && de_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_en) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) begin out_d = dec; state_d = StOne; end
        StOne: begin
          if (accept && issue) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = StTwo;
          end else if (issue) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (issue) begin out_d = skid_q; state_d = StOne; end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign de_pc      = out_q.pc;
  assign de_pc_next = out_q.pc_next;
  assign de_istr    = out_q.istr;
  assign de_opclass = out_q.opclass;
  assign de_funct3  = out_q.funct3;
  assign de_funct7  = out_q.funct7;
  assign de_rs1     = out_q.rs1;
  assign de_rs2     = out_q.rs2;
  assign de_rd      = out_q.rd;
  assign de_rs1_en  = out_q.rs1_en;
  assign de_rs2_en  = out_q.rs2_en;
  assign de_rd_en   = out_q.rd_en;
  assign de_imm     = out_q.imm;
  assign de_jump    = out_q.jump;
  assign de_illegal = out_q.illegal;

endmodule
